// File: rtl/punc_program_loader.sv
// Program loader for the PUnC core: streams a word image into LC3 memory through
// its write port and holds the core in reset until the whole image has landed.
module punc_program_loader #(
  parameter int MEM_WORDS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             mem_w_en,
  output logic [15:0]      mem_w_addr,
  output logic [15:0]      mem_w_data,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [15:0]      checksum
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [15:0]      addr_ptr_r, addr_ptr_nxt_s;
  logic [CNT_W-1:0] remaining_r, remaining_nxt_s;
  logic [15:0]      checksum_r, checksum_nxt_s;
  logic             mem_w_en_r, mem_w_en_nxt_s;
  logic [15:0]      mem_w_addr_r, mem_w_addr_nxt_s;
  logic [15:0]      mem_w_data_r, mem_w_data_nxt_s;
  logic             core_rst_r, busy_r, done_r, error_r;
  logic             handshake_s;
  logic [16:0]      end_addr_s;
  logic             range_bad_s;

  // Handshake gating: abort withdraws ready in the very cycle it is seen.
  always_comb begin
    in_ready    = (state_r == ST_LOAD) && !abort;
    handshake_s = in_ready && in_valid;
    // 17-bit sum so an image ending exactly at MEM_WORDS is legal and wrap is caught
    end_addr_s  = 17'(base_addr) + 17'(word_count);
    range_bad_s = (end_addr_s > 17'(MEM_WORDS));
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nxt_s      = state_r;
    addr_ptr_nxt_s   = addr_ptr_r;
    remaining_nxt_s  = remaining_r;
    checksum_nxt_s   = checksum_r;
    mem_w_en_nxt_s   = 1'b0;
    mem_w_addr_nxt_s = mem_w_addr_r;
    mem_w_data_nxt_s = mem_w_data_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          checksum_nxt_s = 16'd0;
          if (range_bad_s) begin
            state_nxt_s = ST_ERR;
          end else if (word_count == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s     = ST_LOAD;
            addr_ptr_nxt_s  = base_addr;
            remaining_nxt_s = word_count;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (handshake_s) begin
          mem_w_en_nxt_s   = 1'b1;
          mem_w_addr_nxt_s = addr_ptr_r;
          mem_w_data_nxt_s = in_data;
          addr_ptr_nxt_s   = addr_ptr_r + 16'd1;
          remaining_nxt_s  = remaining_r - CNT_W'(1);
          checksum_nxt_s   = checksum_r + in_data;
          if (remaining_r == CNT_W'(1)) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      addr_ptr_r   <= 16'd0;
      remaining_r  <= {CNT_W{1'b0}};
      checksum_r   <= 16'd0;
      mem_w_en_r   <= 1'b0;
      mem_w_addr_r <= 16'd0;
      mem_w_data_r <= 16'd0;
      core_rst_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      addr_ptr_r   <= addr_ptr_nxt_s;
      remaining_r  <= remaining_nxt_s;
      checksum_r   <= checksum_nxt_s;
      mem_w_en_r   <= mem_w_en_nxt_s;
      mem_w_addr_r <= mem_w_addr_nxt_s;
      mem_w_data_r <= mem_w_data_nxt_s;
      core_rst_r   <= (state_nxt_s != ST_DONE);
      busy_r       <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_FLUSH);
      done_r       <= (state_nxt_s == ST_DONE);
      error_r      <= (state_nxt_s == ST_ERR);
    end
  end

  assign mem_w_en   = mem_w_en_r;
  assign mem_w_addr = mem_w_addr_r;
  assign mem_w_data = mem_w_data_r;
  assign core_rst   = core_rst_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign checksum   = checksum_r;

endmodule

// File: tb/tb_punc_program_loader.sv
// Bench for punc_program_loader: expected memory writes are queued as words are
// accepted and compared as the write port fires.
module tb_punc_program_loader;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid;
  logic [15:0]      base_addr, in_data;
  logic [CNT_W-1:0] word_count;
  logic             in_ready, mem_w_en, core_rst, busy, done, error;
  logic [15:0]      mem_w_addr, mem_w_data, checksum;

  int          errors = 0;
  int          checks = 0;
  int          nwrites = 0;
  logic [31:0] sb[$];
  logic [15:0] wbuf[8];
  logic        vpat[16];
  logic [15:0] exp_sum;
  logic [15:0] cur_base;
  int          cyc;

  punc_program_loader #(.MEM_WORDS(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every write must match the oldest accepted word.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_w_en === 1'b1) begin
      nwrites++;
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("wr_addr_data", {mem_w_addr, mem_w_data}, sb.pop_front());
    end
  end

  // Called at posedge+1; start is sampled at the following edge.
  task automatic do_start(input logic [15:0] b, input logic [CNT_W-1:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    cur_base = b; exp_sum = 16'd0; nwrites = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, output int cycles);
    int  i;
    logic hs;
    i = 0; cycles = 0;
    while (i < n && cycles < 40) begin
      in_valid = vpat[cycles % 16];
      in_data  = wbuf[i];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sb.push_back({cur_base + 16'(i), wbuf[i]});
        exp_sum = exp_sum + wbuf[i];
        i++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    chk("stream_accepted", 32'(i), 32'(n));
  endtask

  // After the last handshake: one FLUSH cycle, then DONE.
  task automatic finish_load(input string tag);
    @(negedge clk);
    chk({tag, "_flush_done"}, 32'(done), 32'd0);
    chk({tag, "_flush_busy"}, 32'(busy), 32'd1);
    chk({tag, "_flush_rdy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wen"}, 32'(mem_w_en), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = 16'd0; in_data = 16'd0; word_count = '0;
    exp_sum = 16'd0; cur_base = 16'd0;
    #12;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    chk("rst_wen_rdy", {30'd0, mem_w_en, in_ready}, 32'd0);
    chk("rst_addr_data", {mem_w_addr, mem_w_data}, 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // 1: three words, valid held high
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD; wbuf[2] = 16'h0001;
    for (int k = 0; k < 16; k++) vpat[k] = 1'b1;
    do_start(16'h0000, 11'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    stream(3, cyc);
    chk("t1_cycles", 32'(cyc), 32'd3);
    chk("t1_model_sum", 32'(exp_sum), 32'h0000BE02);
    finish_load("t1");
    chk("t1_nwrites", 32'(nwrites), 32'd3);

    // 2: top-of-memory load with a gap in valid
    wbuf[0] = 16'h0F0F; wbuf[1] = 16'h1010;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b1;
    do_start(16'h03FE, 11'd2);
    stream(2, cyc);
    chk("t2_cycles", 32'(cyc), 32'd3);
    finish_load("t2");
    chk("t2_nwrites", 32'(nwrites), 32'd2);

    // 3: out-of-range image goes to ERR, then a good load recovers
    do_start(16'h03FF, 11'd2);
    @(negedge clk);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_core_rst", 32'(core_rst), 32'd1);
    chk("t3_busy_done", {30'd0, busy, done}, 32'd0);
    chk("t3_rdy", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_nwrites", 32'(nwrites), 32'd0);
    chk("t3_err_hold", 32'(error), 32'd1);
    wbuf[0] = 16'h5555;
    for (int k = 0; k < 16; k++) vpat[k] = 1'b1;
    do_start(16'h0000, 11'd1);
    chk("t3b_error_clr", 32'(error), 32'd0);
    stream(1, cyc);
    finish_load("t3b");
    chk("t3b_nwrites", 32'(nwrites), 32'd1);

    // 4: zero-length image completes immediately with cleared checksum
    do_start(16'h0010, 11'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_core_rst", 32'(core_rst), 32'd0);
    chk("t4_checksum", 32'(checksum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_nwrites", 32'(nwrites), 32'd0);

    // 5: abort after the second handshake
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    do_start(16'h0020, 11'd4);
    stream(2, cyc);
    in_valid = 1'b1; in_data = wbuf[2]; abort = 1'b1;
    @(negedge clk);
    chk("t5_rdy_abort", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_idle_flags", {29'd0, busy, done, error}, 32'd0);
    chk("t5_core_rst", 32'(core_rst), 32'd1);
    chk("t5_rdy", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    chk("t5_nwrites", 32'(nwrites), 32'd2);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: asynchronous reset in the middle of a load
    wbuf[0] = 16'hBEEF;
    do_start(16'h0100, 11'd4);
    stream(1, cyc);
    #1; rst = 1'b0;
    #1;
    chk("t6_wen", 32'(mem_w_en), 32'd0);
    chk("t6_flags", {28'd0, core_rst, busy, done, error}, 32'h8);
    chk("t6_addr_data", {mem_w_addr, mem_w_data}, 32'd0);
    chk("t6_checksum", 32'(checksum), 32'd0);
    chk("t6_rdy", 32'(in_ready), 32'd0);
    sb.delete();
    nwrites = 0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    repeat (4) @(posedge clk);
    #1; in_valid = 1'b0;
    chk("t6_nwrites", 32'(nwrites), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
